// File: rtl/tristate_bus_arb.sv
// Round-robin arbiter that gives one of N requesters the shared tristate bus, with bounded bursts and idle turnaround gaps.
// Latency: grant one edge after req is sampled; y follows data_in of the owner combinationally while busy.
// Backpressure: requesters hold req until served; each grant lasts at most MAXB driven cycles, then TURN high-Z cycles follow.
module tristate_bus_arb #(
    parameter int N    = 4,
    parameter int W    = 4,
    parameter int MAXB = 4,
    parameter int TURN = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       data_in,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] owner,
    output logic                 busy,
    inout  tri   [W-1:0]         y
);

    localparam int PW = $clog2(N);

    // Last beat index of a burst and last cycle index of the turnaround gap.
    localparam logic [7:0] BEAT_LAST = 8'(MAXB - 1);
    localparam logic [2:0] TURN_LAST = (TURN > 0) ? 3'(TURN - 1) : 3'd0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        TURN_S = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    gnt_q,   gnt_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [PW-1:0]   ptr_q,   ptr_d;
    logic            busy_q,  busy_d;
    logic [7:0]      beat_q,  beat_d;
    logic [2:0]      turn_q,  turn_d;

    logic            arb_hit;
    logic [PW-1:0]   arb_idx;
    logic            do_grant;
    logic            do_idle;
    logic            owner_rel;

    // Round-robin search: first active requester after the pointer, wrapping mod N.
    // An X on req evaluates false in the if, so unknown requests never win.
    always_comb begin
        int unsigned idx;
        arb_hit = 1'b0;
        arb_idx = '0;
        idx     = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr_q) + k) % N;
            if (!arb_hit && req[idx]) begin
                arb_hit = 1'b1;
                arb_idx = PW'(idx);
            end
        end
    end

    // The owner gives the bus up when it drops its request or exhausts its burst.
    assign owner_rel = !req[owner_q] || (beat_q == BEAT_LAST);

    // Next-state and registered-output logic for the IDLE / DRIVE / TURN sequence.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        busy_d   = busy_q;
        beat_d   = beat_q;
        turn_d   = turn_q;
        do_grant = 1'b0;
        do_idle  = 1'b0;

        case (state_q)
            IDLE: begin
                if (arb_hit) begin
                    do_grant = 1'b1;
                end
            end
            DRIVE: begin
                if (owner_rel) begin
                    if (TURN > 0) begin
                        state_d = TURN_S;
                        gnt_d   = '0;
                        busy_d  = 1'b0;
                        turn_d  = 3'd0;
                    end else if (arb_hit) begin
                        // Zero-gap handover straight to the next owner.
                        do_grant = 1'b1;
                    end else begin
                        do_idle = 1'b1;
                    end
                end else begin
                    beat_d = beat_q + 8'd1;
                end
            end
            TURN_S: begin
                if (turn_q == TURN_LAST) begin
                    if (arb_hit) begin
                        do_grant = 1'b1;
                    end else begin
                        do_idle = 1'b1;
                    end
                end else begin
                    turn_d = turn_q + 3'd1;
                end
            end
            default: begin
                do_idle = 1'b1;
            end
        endcase

        // A new grant moves the pointer onto the winner so it becomes lowest priority next time.
        if (do_grant) begin
            state_d        = DRIVE;
            gnt_d          = '0;
            gnt_d[arb_idx] = 1'b1;
            owner_d        = arb_idx;
            ptr_d          = arb_idx;
            busy_d         = 1'b1;
            beat_d         = 8'd0;
        end

        if (do_idle) begin
            state_d = IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
        end
    end

    // State registers; reset leaves the pointer at N-1 so requester 0 wins first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= PW'(N - 1);
            busy_q  <= 1'b0;
            beat_q  <= 8'd0;
            turn_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            beat_q  <= beat_d;
            turn_q  <= turn_d;
        end
    end

    assign gnt   = gnt_q;
    assign owner = owner_q;
    assign busy  = busy_q;

    // The only driver of the shared net; released whenever busy is low.
    assign y = busy_q ? data_in[owner_q*W +: W] : {W{1'bz}};

    // Single-driver guarantees.
    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!reset_n) $onehot0(gnt_q));
    a_busy_gnt    : assert property (@(posedge clk) disable iff (!reset_n) busy_q == (|gnt_q));
    a_owner_gnt   : assert property (@(posedge clk) disable iff (!reset_n) gnt_q[owner_q] == busy_q);
    a_no_drive    : assert property (@(posedge clk) disable iff (!reset_n) (state_q != DRIVE) |-> !busy_q);

endmodule

// File: tb/tb_tristate_bus_arb.sv
module tb_tristate_bus_arb;

    logic        clk;
    logic        reset_n;
    logic [3:0]  req;
    logic [15:0] data_in;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic        busy;
    tri   [3:0]  y;

    logic        rst2_n;
    logic [3:0]  req2;
    logic [15:0] din2;
    logic [3:0]  gnt2;
    logic [1:0]  owner2;
    logic        busy2;
    tri   [3:0]  y2;

    int vectors;
    int miscompares;

    tristate_bus_arb #(.N(4), .W(4), .MAXB(4), .TURN(1)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .data_in(data_in),
        .gnt(gnt), .owner(owner), .busy(busy), .y(y)
    );

    tristate_bus_arb #(.N(4), .W(4), .MAXB(2), .TURN(0)) dut2 (
        .clk(clk), .reset_n(rst2_n), .req(req2), .data_in(din2),
        .gnt(gnt2), .owner(owner2), .busy(busy2), .y(y2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        req     = 4'b0000;
        #3;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        req     = 4'b1111;
        data_in = 16'h356A;
        tick(); tick(); tick();
        vectors++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || owner !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_hold: gnt=%b busy=%b owner=%0d, want 0000 0 0", gnt, busy, owner);
        end
        vectors++;
        if (y !== 4'bzzzz && y !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_hold_y: y=%b, want zzzz", y);
        end
        // Start a burst, then pull reset asynchronously in the middle of a cycle.
        reset_n = 1'b1;
        req     = 4'b0001;
        tick();
        vectors++;
        if (gnt !== 4'b0001 || y !== 4'b1010) begin
            miscompares++;
            $display("FAIL reset_pre_drive: gnt=%b y=%b, want 0001 1010", gnt, y);
        end
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || gnt !== 4'b0000 || (y !== 4'bzzzz && y !== 4'b0000)) begin
            miscompares++;
            $display("FAIL reset_async: busy=%b gnt=%b y=%b, want 0 0000 zzzz", busy, gnt, y);
        end
        tick();
        req     = 4'b0000;
        reset_n = 1'b1;
    endtask

    task automatic test_single;
        do_reset();
        data_in = 16'h356A;
        req     = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (gnt !== 4'b0001 || busy !== 1'b1 || owner !== 2'd0 || y !== 4'b1010) begin
                miscompares++;
                $display("FAIL single_drive[%0d]: gnt=%b busy=%b owner=%0d y=%b, want 0001 1 0 1010", i, gnt, busy, owner, y);
            end
        end
        tick();
        vectors++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || (y !== 4'bzzzz && y !== 4'b0000)) begin
            miscompares++;
            $display("FAIL single_gap: gnt=%b busy=%b y=%b, want 0000 0 zzzz", gnt, busy, y);
        end
        tick();
        vectors++;
        if (gnt !== 4'b0001 || y !== 4'b1010) begin
            miscompares++;
            $display("FAIL single_regrant: gnt=%b y=%b, want 0001 1010", gnt, y);
        end
    endtask

    task automatic test_round_robin;
        logic [1:0] exp_owner [4];
        logic [3:0] exp_y     [4];
        exp_owner = '{2'd0, 2'd2, 2'd0, 2'd2};
        exp_y     = '{4'hA, 4'h5, 4'hA, 4'h5};
        do_reset();
        data_in = 16'h356A;
        req     = 4'b0101;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 4; i++) begin
                tick();
                vectors++;
                if (owner !== exp_owner[b] || gnt !== (4'b0001 << exp_owner[b]) || y !== exp_y[b]) begin
                    miscompares++;
                    $display("FAIL rr_burst%0d_beat%0d: owner=%0d gnt=%b y=%b, want %0d %b %b",
                             b, i, owner, gnt, y, exp_owner[b], 4'b0001 << exp_owner[b], exp_y[b]);
                end
            end
            tick();
            vectors++;
            if (gnt !== 4'b0000 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL rr_gap%0d: gnt=%b busy=%b, want 0000 0", b, gnt, busy);
            end
        end
    endtask

    task automatic test_early_release;
        do_reset();
        data_in = 16'h356A;
        req     = 4'b0011;
        tick();
        vectors++;
        if (gnt !== 4'b0001 || owner !== 2'd0) begin
            miscompares++;
            $display("FAIL early_grant: gnt=%b owner=%0d, want 0001 0", gnt, owner);
        end
        tick();
        req = 4'b0010;
        tick();
        vectors++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || (y !== 4'bzzzz && y !== 4'b0000)) begin
            miscompares++;
            $display("FAIL early_release: gnt=%b busy=%b y=%b, want 0000 0 zzzz", gnt, busy, y);
        end
        tick();
        vectors++;
        if (gnt !== 4'b0010 || owner !== 2'd1 || y !== 4'b0110) begin
            miscompares++;
            $display("FAIL early_next: gnt=%b owner=%0d y=%b, want 0010 1 0110", gnt, owner, y);
        end
    endtask

    task automatic test_back_to_back;
        logic [1:0] eo;
        logic [3:0] ed;
        logic [3:0] d1;
        do_reset();
        rst2_n = 1'b0;
        req2   = 4'b0000;
        din2   = 16'h0FC5;
        d1     = 4'b1100;
        tick();
        rst2_n = 1'b1;
        req2   = 4'b0011;
        for (int k = 0; k < 6; k++) begin
            tick();
            eo = 2'((k / 2) % 2);
            ed = (eo == 2'd0) ? 4'b0101 : d1;
            vectors++;
            if (busy2 !== 1'b1 || owner2 !== eo || gnt2 !== (4'b0001 << eo) || y2 !== ed) begin
                miscompares++;
                $display("FAIL b2b[%0d]: busy=%b owner=%0d gnt=%b y=%b, want 1 %0d %b %b",
                         k, busy2, owner2, gnt2, y2, eo, 4'b0001 << eo, ed);
            end
            if (k == 2) begin
                #2;
                din2[7:4] = 4'b0011;
                d1        = 4'b0011;
                #1;
                vectors++;
                if (y2 !== 4'b0011) begin
                    miscompares++;
                    $display("FAIL b2b_live_data: y=%b, want 0011", y2);
                end
            end
        end
        req2   = 4'b0000;
        rst2_n = 1'b0;
    endtask

    task automatic test_disabled_change;
        do_reset();
        data_in = 16'h356A;
        req     = 4'b0001;
        for (int i = 0; i < 5; i++) tick();
        data_in = 16'hFFFF;
        #1;
        vectors++;
        if (busy !== 1'b0 || (y !== 4'bzzzz && y !== 4'b0000)) begin
            miscompares++;
            $display("FAIL turn_data_change: busy=%b y=%b, want 0 zzzz", busy, y);
        end
        tick();
        vectors++;
        if (gnt !== 4'b0001 || y !== 4'b1111) begin
            miscompares++;
            $display("FAIL turn_regrant: gnt=%b y=%b, want 0001 1111", gnt, y);
        end
        // Owner 2 mid-burst, then a reset; afterwards the lowest active index must win.
        do_reset();
        data_in = 16'h356A;
        req     = 4'b0100;
        tick();
        vectors++;
        if (owner !== 2'd2 || gnt !== 4'b0100) begin
            miscompares++;
            $display("FAIL midburst_owner: owner=%0d gnt=%b, want 2 0100", owner, gnt);
        end
        tick();
        #2;
        reset_n = 1'b0;
        req     = 4'b1010;
        tick();
        reset_n = 1'b1;
        tick();
        vectors++;
        if (owner !== 2'd1 || gnt !== 4'b0010 || y !== 4'b0110) begin
            miscompares++;
            $display("FAIL post_reset_prio: owner=%0d gnt=%b y=%b, want 1 0010 0110", owner, gnt, y);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        req         = 4'b0000;
        data_in     = 16'h356A;
        rst2_n      = 1'b0;
        req2        = 4'b0000;
        din2        = 16'h0FC5;
        test_reset();
        test_single();
        test_round_robin();
        test_early_release();
        test_back_to_back();
        test_disabled_change();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
